in_bcd: RTL and testbench

IN_BCD -- requirements
Module: in_bcd

---
 rtl/in_bcd_pkg.sv | 24 ++
 rtl/in_bcd_step.sv | 23 ++
 rtl/in_bcd.sv | 110 +++++++++++
 tb/tb_in_bcd.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/in_bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Consumers: in_bcd, in_bcd_step.
package in_bcd_pkg;

   localparam int unsigned N_DIGITS = 4;
   localparam int unsigned N_BITS   = 16;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_e;

   // True when any nibble of a packed BCD word is outside 0..9.
   function automatic logic has_invalid(input logic [N_BITS-1:0] bcd);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < int'(N_DIGITS); i++) begin
         if (bcd[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

endpackage

// File: rtl/in_bcd_step.sv
// One reverse double-dabble step: shift {bcd,bin} right, then correct
// every BCD nibble that picked up a carry (>=8) by subtracting 3.
module in_bcd_step
   import in_bcd_pkg::*;
(
   input  logic [2*N_BITS-1:0] i_data,
   output logic [2*N_BITS-1:0] o_data
);

   logic [2*N_BITS-1:0] w_shift;

   assign w_shift = i_data >> 1;

   always_comb begin
      o_data = w_shift;
      for (int i = 0; i < int'(N_DIGITS); i++) begin
         if (w_shift[N_BITS + 4*i +: 4] >= 4'd8) begin
            o_data[N_BITS + 4*i +: 4] = w_shift[N_BITS + 4*i +: 4] - 4'd3;
         end
      end
   end

endmodule

// File: rtl/in_bcd.sv
// Four-digit BCD to binary converter, one shift-and-correct step per cycle.
// Define IN_BCD_VALIDATE_EN to reject digits above 9 and report them on erro.
module in_bcd
   import in_bcd_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  setseg1,
   input  logic [3:0]  setseg2,
   input  logic [3:0]  setseg3,
   input  logic [3:0]  setseg4,
   input  logic        ler,
   output logic [31:0] saida,
   output logic        pronto,
   output logic        ocupado,
   output logic        erro
);

   state_e              r_state;
   state_e              w_next;
   logic [N_BITS-1:0]   r_bcd;
   logic [N_BITS-1:0]   r_bin;
   logic [4:0]          r_cnt;
   logic [31:0]         r_saida;
   logic                r_pronto;
   logic                r_bad;
   logic                w_invalid;
   logic [N_BITS-1:0]   w_digits;
   logic [2*N_BITS-1:0] w_step_out;

   assign w_digits = {setseg4, setseg3, setseg2, setseg1};

`ifdef IN_BCD_VALIDATE_EN
   assign w_invalid = has_invalid(w_digits);
`else
   assign w_invalid = 1'b0;
`endif

   in_bcd_step u_step (
      .i_data (({r_bcd, r_bin})),
      .o_data (w_step_out)
   );

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (ler) w_next = w_invalid ? DONE : CONV;
         CONV: if (r_cnt == 5'(N_BITS - 1)) w_next = DONE;
         DONE: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_bcd    <= '0;
         r_bin    <= '0;
         r_cnt    <= '0;
         r_saida  <= '0;
         r_pronto <= 1'b0;
         r_bad    <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_pronto <= (r_state == DONE);
         unique case (r_state)
            IDLE: begin
               if (ler) begin
                  r_bcd <= w_digits;
                  r_bin <= '0;
                  r_cnt <= '0;
                  r_bad <= w_invalid;
               end
            end
            CONV: begin
               {r_bcd, r_bin} <= w_step_out;
               r_cnt          <= r_cnt + 5'd1;
            end
            DONE: begin
               // A rejected request leaves the previous result visible.
               if (!r_bad) r_saida <= {16'b0, r_bin};
            end
            default: ;
         endcase
      end
   end

`ifdef IN_BCD_VALIDATE_EN
   logic r_erro;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_erro <= 1'b0;
      end else if (r_state == IDLE && ler) begin
         r_erro <= 1'b0;
      end else if (r_state == DONE && r_bad) begin
         r_erro <= 1'b1;
      end
   end

   assign erro = r_erro;
`else
   assign erro = 1'b0;
`endif

   assign saida   = r_saida;
   assign pronto  = r_pronto;
   assign ocupado = (r_state != IDLE);

endmodule

// File: tb/tb_in_bcd.sv
// Directed, table-driven bench for in_bcd: latency, results, held request,
// mid-conversion reset and (when IN_BCD_VALIDATE_EN is defined) digit rejection.
module tb_in_bcd;

   logic        clock;
   logic        reset;
   logic [3:0]  setseg1, setseg2, setseg3, setseg4;
   logic        ler;
   logic [31:0] saida;
   logic        pronto, ocupado, erro;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] digits;
      logic [31:0] expect_val;
   } vec_t;

   vec_t vecs[7];

   in_bcd dut (
      .clock   (clock),
      .reset   (reset),
      .setseg1 (setseg1),
      .setseg2 (setseg2),
      .setseg3 (setseg3),
      .setseg4 (setseg4),
      .ler     (ler),
      .saida   (saida),
      .pronto  (pronto),
      .ocupado (ocupado),
      .erro    (erro)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_digits(input logic [15:0] d);
      setseg4 = d[15:12];
      setseg3 = d[11:8];
      setseg2 = d[7:4];
      setseg1 = d[3:0];
   endtask

   // Single ler pulse; checks latency, busy time, result and pulse width.
   task automatic convert(input logic [15:0] d, input logic [31:0] exp);
      int cyc;
      int occ;
      set_digits(d);
      ler = 1'b1;
      tick();
      ler = 1'b0;
      cyc = 0;
      occ = 0;
      while (!pronto && cyc < 40) begin
         if (ocupado) occ++;
         tick();
         cyc++;
      end
      chk($sformatf("latency %h", d), cyc, 17);
      chk($sformatf("saida %h", d), saida, exp);
      chk($sformatf("ocupado_cycles %h", d), occ, 17);
      chk($sformatf("erro %h", d), {31'b0, erro}, 32'd0);
      tick();
      chk($sformatf("pronto_width %h", d), {31'b0, pronto}, 32'd0);
      chk($sformatf("hold_saida %h", d), saida, exp);
   endtask

   initial begin
      int cyc;
      int np;

      vecs[0] = '{16'h1234, 32'h0000_04D2};
      vecs[1] = '{16'h9999, 32'h0000_270F};
      vecs[2] = '{16'h0000, 32'h0000_0000};
      vecs[3] = '{16'h0042, 32'h0000_002A};
      vecs[4] = '{16'h8080, 32'h0000_1F90};
      vecs[5] = '{16'h0001, 32'h0000_0001};
      vecs[6] = '{16'h5000, 32'h0000_1388};

      reset = 1'b1;
      ler   = 1'b0;
      set_digits(16'h0000);
      tick();
      chk("reset_saida", saida, 32'd0);
      chk("reset_flags", {29'b0, pronto, ocupado, erro}, 32'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 7; i++) begin
         convert(vecs[i].digits, vecs[i].expect_val);
         tick();
      end

      // Held ler: back-to-back results, digit changes mid-conversion ignored.
      set_digits(16'h0042);
      ler = 1'b1;
      tick();
      cyc = 0;
      while (!pronto && cyc < 40) begin
         tick();
         cyc++;
         if (cyc == 5) set_digits(16'h9999);
         if (cyc == 10) set_digits(16'h0042);
      end
      chk("held_first_latency", cyc, 17);
      chk("held_first_saida", saida, 32'h2A);
      cyc = 0;
      tick();
      cyc++;
      while (!pronto && cyc < 40) begin
         tick();
         cyc++;
         if (cyc == 5) set_digits(16'h7777);
         if (cyc == 10) set_digits(16'h0042);
      end
      ler = 1'b0;
      chk("held_period", cyc, 18);
      chk("held_second_saida", saida, 32'h2A);
      tick();
      chk("held_release_idle", {31'b0, ocupado}, 32'd0);

      // Reset after step 8 of 5000 aborts the conversion.
      set_digits(16'h5000);
      ler = 1'b1;
      tick();
      ler = 1'b0;
      repeat (8) tick();
      chk("abort_busy_before", {31'b0, ocupado}, 32'd1);
      reset = 1'b1;
      #1;
      chk("abort_ocupado", {31'b0, ocupado}, 32'd0);
      chk("abort_saida", saida, 32'd0);
      tick();
      reset = 1'b0;
      np = 0;
      for (int k = 0; k < 25; k++) begin
         if (pronto) np++;
         tick();
      end
      chk("abort_no_pronto", np, 0);
      chk("abort_saida_held", saida, 32'd0);
      convert(16'h5000, 32'h1388);
      tick();

`ifdef IN_BCD_VALIDATE_EN
      set_digits(16'h1A00);
      ler = 1'b1;
      tick();
      ler = 1'b0;
      cyc = 0;
      while (!pronto && cyc < 40) begin
         tick();
         cyc++;
      end
      chk("invalid_latency", cyc, 1);
      chk("invalid_erro", {31'b0, erro}, 32'd1);
      chk("invalid_saida", saida, 32'h1388);
      tick();
      chk("invalid_pronto_width", {31'b0, pronto}, 32'd0);
      chk("invalid_erro_sticky", {31'b0, erro}, 32'd1);
      convert(16'h0007, 32'h7);
`else
      // Without validation, nibble A weighs 10 like any other digit.
      convert(16'h1A00, 32'h07D0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
